// File: rtl/dlsc_pcie_s6_outbound_tlp_wrr.sv
// Outbound memory-request TLP generator: weighted round-robin read/write header
// arbitration, 3DW/4DW header formatting, write payload and a registered skid output.
module dlsc_pcie_s6_outbound_tlp_wrr #(
  parameter int ADDR      = 32,
  parameter int TAG       = 5,
  parameter int RD_WEIGHT = 2,
  parameter int WR_WEIGHT = 2
) (
  input  logic            clk,
  input  logic            rst,

  output logic            trans_req,
  output logic [ADDR-3:0] trans_req_addr,
  input  logic            trans_ack,
  input  logic [61:0]     trans_ack_addr,
  input  logic            trans_ack_64,

  output logic            rd_tlp_h_ready,
  input  logic            rd_tlp_h_valid,
  input  logic [ADDR-3:0] rd_tlp_h_addr,
  input  logic [9:0]      rd_tlp_h_len,
  input  logic [TAG-1:0]  rd_tlp_h_tag,
  input  logic [3:0]      rd_tlp_h_be_first,
  input  logic [3:0]      rd_tlp_h_be_last,
  input  logic [2:0]      rd_tlp_h_tc,
  input  logic [1:0]      rd_tlp_h_attr,

  output logic            wr_tlp_h_ready,
  input  logic            wr_tlp_h_valid,
  input  logic [ADDR-3:0] wr_tlp_h_addr,
  input  logic [9:0]      wr_tlp_h_len,
  input  logic [3:0]      wr_tlp_h_be_first,
  input  logic [3:0]      wr_tlp_h_be_last,
  input  logic [2:0]      wr_tlp_h_tc,
  input  logic [1:0]      wr_tlp_h_attr,

  output logic            wr_tlp_d_ready,
  input  logic            wr_tlp_d_valid,
  input  logic [31:0]     wr_tlp_d_data,

  input  logic            tlp_ready,
  output logic            tlp_valid,
  output logic [31:0]     tlp_data,
  output logic            tlp_last,

  input  logic [7:0]      bus_number,
  input  logic [4:0]      dev_number,
  input  logic [2:0]      func_number
);

  typedef enum logic [2:0] {S_H0, S_H1, S_H2, S_H3, S_DATA} state_t;

  typedef struct packed {
    logic            wr;
    logic [ADDR-3:0] addr;
    logic [9:0]      len;
    logic [7:0]      tag;
    logic [3:0]      be_last;
    logic [3:0]      be_first;
    logic [2:0]      tc;
    logic [1:0]      attr;
  } hdr_t;

  localparam logic [3:0] RD_W = 4'(RD_WEIGHT);
  localparam logic [3:0] WR_W = 4'(WR_WEIGHT);

  state_t          state, state_n;
  hdr_t            hdr, hdr_in;
  logic            h_valid;
  logic            last_wr;
  logic [3:0]      run;
  logic            favour_rd, grant_rd, grant_wr, accept;
  logic            is64;
  logic [31:0]     addr_lo;
  logic [10:0]     dcnt;
  logic            int_valid, int_ready, int_last, int_hs, retire, pop;
  logic [31:0]     int_data;
  logic [1:0][32:0] skid;
  logic            wptr, rptr;
  logic [1:0]      fill;

  // Once the run of the last-granted type hits its weight, the other type wins a tie.
  always_comb begin
    favour_rd = last_wr ? (run >= WR_W) : (run < RD_W);
    grant_rd  = rd_tlp_h_valid && (!wr_tlp_h_valid || favour_rd);
    grant_wr  = wr_tlp_h_valid && (!rd_tlp_h_valid || !favour_rd);
  end

  assign rd_tlp_h_ready = !h_valid && rd_tlp_h_valid && grant_rd;
  assign wr_tlp_h_ready = !h_valid && wr_tlp_h_valid && grant_wr;
  assign accept         = rd_tlp_h_ready || wr_tlp_h_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr <= 1'b0;
      run     <= '0;
    end else if (accept) begin
      if (wr_tlp_h_ready == last_wr) begin
        run <= (run == 4'hF) ? run : run + 4'd1;
      end else begin
        last_wr <= wr_tlp_h_ready;
        run     <= 4'd1;
      end
    end
  end

  always_comb begin
    hdr_in = '0;
    if (wr_tlp_h_ready) begin
      hdr_in.wr       = 1'b1;
      hdr_in.addr     = wr_tlp_h_addr;
      hdr_in.len      = wr_tlp_h_len;
      hdr_in.be_first = wr_tlp_h_be_first;
      hdr_in.be_last  = wr_tlp_h_be_last;
      hdr_in.tc       = wr_tlp_h_tc;
      hdr_in.attr     = wr_tlp_h_attr;
    end else begin
      hdr_in.addr     = rd_tlp_h_addr;
      hdr_in.len      = rd_tlp_h_len;
      hdr_in.tag      = 8'(rd_tlp_h_tag);
      hdr_in.be_first = rd_tlp_h_be_first;
      hdr_in.be_last  = rd_tlp_h_be_last;
      hdr_in.tc       = rd_tlp_h_tc;
      hdr_in.attr     = rd_tlp_h_attr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid <= 1'b0;
      hdr     <= '0;
    end else if (accept) begin
      h_valid <= 1'b1;
      hdr     <= hdr_in;
    end else if (retire) begin
      h_valid <= 1'b0;
    end
  end

  assign trans_req      = h_valid;
  assign trans_req_addr = hdr.addr;

  // A 64-bit translation whose upper half is zero still goes out as 3DW.
  assign is64    = trans_ack_64 && (|trans_ack_addr[61:30]);
  assign addr_lo = {trans_ack_addr[29:0], 2'b00};

  always_comb begin
    state_n        = state;
    int_valid      = 1'b0;
    int_data       = '0;
    int_last       = 1'b0;
    wr_tlp_d_ready = 1'b0;
    case (state)
      S_H0: begin
        int_valid = h_valid && trans_ack;
        int_data  = {1'b0, hdr.wr, is64, 5'd0, 1'b0, hdr.tc, 6'd0, hdr.attr, 2'd0, hdr.len};
        if (int_valid && int_ready) state_n = S_H1;
      end
      S_H1: begin
        int_valid = 1'b1;
        int_data  = {bus_number, dev_number, func_number, hdr.tag, hdr.be_last, hdr.be_first};
        if (int_ready) state_n = S_H2;
      end
      S_H2: begin
        int_valid = 1'b1;
        int_data  = is64 ? trans_ack_addr[61:30] : addr_lo;
        int_last  = !is64 && !hdr.wr;
        if (int_ready) state_n = is64 ? S_H3 : (hdr.wr ? S_DATA : S_H0);
      end
      S_H3: begin
        int_valid = 1'b1;
        int_data  = addr_lo;
        int_last  = !hdr.wr;
        if (int_ready) state_n = hdr.wr ? S_DATA : S_H0;
      end
      S_DATA: begin
        int_valid      = wr_tlp_d_valid;
        int_data       = wr_tlp_d_data;
        int_last       = (dcnt == 11'd1);
        wr_tlp_d_ready = int_ready;
        if (int_valid && int_ready && dcnt == 11'd1) state_n = S_H0;
      end
      default: state_n = S_H0;
    endcase
  end

  assign int_hs = int_valid && int_ready;
  assign retire = int_hs && ((state == S_H2 && !is64) || state == S_H3);

  always_ff @(posedge clk) begin
    if (rst) state <= S_H0;
    else     state <= state_n;
  end

  // Reloaded from the held header until DATA starts, so a header accepted mid-payload is harmless.
  always_ff @(posedge clk) begin
    if (rst)                 dcnt <= '0;
    else if (state != S_DATA) dcnt <= (hdr.len == 10'd0) ? 11'd1024 : {1'b0, hdr.len};
    else if (int_hs)          dcnt <= dcnt - 11'd1;
  end

  // Two-entry skid: int_ready comes straight off a fill register bit, never from tlp_ready.
  assign int_ready = !fill[1];
  assign pop       = tlp_valid && tlp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      skid <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      fill <= '0;
    end else begin
      if (int_hs) begin
        skid[wptr] <= {int_last, int_data};
        wptr       <= !wptr;
      end
      if (pop) rptr <= !rptr;
      fill <= fill + {1'b0, int_hs} - {1'b0, pop};
    end
  end

  assign tlp_valid = |fill;
  assign tlp_data  = tlp_valid ? skid[rptr][31:0] : '0;
  assign tlp_last  = tlp_valid && skid[rptr][32];

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_tlp_wrr.sv
// Bench for the outbound TLP generator: a queue-based TLP model predicts every
// output word; directed tests add literal checks for latency, layout and arbitration.
module tb_dlsc_pcie_s6_outbound_tlp_wrr;
  localparam int ADDR = 32, TAG = 5, RD_WEIGHT = 2, WR_WEIGHT = 1;

  typedef struct {
    logic        wr;
    logic [29:0] addr;
    logic [9:0]  len;
    logic [4:0]  tag;
    logic [3:0]  bef, bel;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [7:0]  seed;
  } hdr_t;

  logic clk = 1'b0, rst = 1'b1;
  logic trans_req, trans_ack, trans_ack_64;
  logic [29:0] trans_req_addr;
  logic [61:0] trans_ack_addr;
  logic rd_tlp_h_ready, rd_tlp_h_valid, wr_tlp_h_ready, wr_tlp_h_valid;
  logic [29:0] rd_tlp_h_addr, wr_tlp_h_addr;
  logic [9:0] rd_tlp_h_len, wr_tlp_h_len;
  logic [TAG-1:0] rd_tlp_h_tag;
  logic [3:0] rd_tlp_h_be_first, rd_tlp_h_be_last, wr_tlp_h_be_first, wr_tlp_h_be_last;
  logic [2:0] rd_tlp_h_tc, wr_tlp_h_tc;
  logic [1:0] rd_tlp_h_attr, wr_tlp_h_attr;
  logic wr_tlp_d_ready, wr_tlp_d_valid;
  logic [31:0] wr_tlp_d_data;
  logic tlp_ready, tlp_valid, tlp_last;
  logic [31:0] tlp_data;
  logic [7:0] bus_number;
  logic [4:0] dev_number;
  logic [2:0] func_number;

  always #5 clk = ~clk;

  dlsc_pcie_s6_outbound_tlp_wrr #(.ADDR(ADDR), .TAG(TAG), .RD_WEIGHT(RD_WEIGHT), .WR_WEIGHT(WR_WEIGHT)) dut (
    .clk(clk), .rst(rst),
    .trans_req(trans_req), .trans_req_addr(trans_req_addr), .trans_ack(trans_ack),
    .trans_ack_addr(trans_ack_addr), .trans_ack_64(trans_ack_64),
    .rd_tlp_h_ready(rd_tlp_h_ready), .rd_tlp_h_valid(rd_tlp_h_valid), .rd_tlp_h_addr(rd_tlp_h_addr),
    .rd_tlp_h_len(rd_tlp_h_len), .rd_tlp_h_tag(rd_tlp_h_tag), .rd_tlp_h_be_first(rd_tlp_h_be_first),
    .rd_tlp_h_be_last(rd_tlp_h_be_last), .rd_tlp_h_tc(rd_tlp_h_tc), .rd_tlp_h_attr(rd_tlp_h_attr),
    .wr_tlp_h_ready(wr_tlp_h_ready), .wr_tlp_h_valid(wr_tlp_h_valid), .wr_tlp_h_addr(wr_tlp_h_addr),
    .wr_tlp_h_len(wr_tlp_h_len), .wr_tlp_h_be_first(wr_tlp_h_be_first), .wr_tlp_h_be_last(wr_tlp_h_be_last),
    .wr_tlp_h_tc(wr_tlp_h_tc), .wr_tlp_h_attr(wr_tlp_h_attr),
    .wr_tlp_d_ready(wr_tlp_d_ready), .wr_tlp_d_valid(wr_tlp_d_valid), .wr_tlp_d_data(wr_tlp_d_data),
    .tlp_ready(tlp_ready), .tlp_valid(tlp_valid), .tlp_data(tlp_data), .tlp_last(tlp_last),
    .bus_number(bus_number), .dev_number(dev_number), .func_number(func_number)
  );

  hdr_t        rd_q[$], wr_q[$];
  logic [31:0] pd_q[$];
  logic [32:0] exp_q[$], obs[$];
  int          obs_cyc[$], grants[$];
  int          checks = 0, errors = 0, cyc = 0;
  logic        bp = 1'b0, d_stall = 1'b0, tr_64 = 1'b0;
  logic [31:0] tr_hi = '0, tr_or = '0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_word = '0;
  logic [15:0] id;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  function automatic logic [32:0] obs_at(input int k);
    if (k < obs.size()) return obs[k];
    return 33'h1_DEAD_BEEF;
  endfunction

  function automatic int cyc_at(input int k);
    if (k < obs_cyc.size()) return obs_cyc[k];
    return -100;
  endfunction

  function automatic logic [31:0] pword(input logic [7:0] seed, input int k);
    return {8'hA5, seed, 16'(k)};
  endfunction

  // Expected words of one TLP, derived from the field layout and the bench translator.
  task automatic model_tlp(input hdr_t h);
    logic [63:0] ta;
    logic        is64;
    logic [31:0] w0, w1;
    int          n;
    ta   = {tr_hi, {h.addr, 2'b00} | tr_or};
    is64 = tr_64 && (ta[63:32] != 32'd0);
    w0 = '0;
    w0[30] = h.wr; w0[29] = is64; w0[22:20] = h.tc; w0[13:12] = h.attr; w0[9:0] = h.len;
    w1 = {id, 8'(h.wr ? 5'd0 : h.tag), h.bel, h.bef};
    exp_q.push_back({1'b0, w0});
    exp_q.push_back({1'b0, w1});
    if (is64) exp_q.push_back({1'b0, ta[63:32]});
    exp_q.push_back({!h.wr, ta[31:0]});
    if (h.wr) begin
      n = (h.len == 10'd0) ? 1024 : int'(h.len);
      for (int k = 0; k < n; k++) begin
        pd_q.push_back(pword(h.seed, k));
        exp_q.push_back({k == n - 1, pword(h.seed, k)});
      end
    end
  endtask

  // One clock: drive inputs after negedge, then sample handshakes and compare outputs.
  task automatic tick();
    logic [63:0] ta;
    @(negedge clk);
    trans_ack      = trans_req;
    ta             = {tr_hi, {trans_req_addr, 2'b00} | tr_or};
    trans_ack_addr = ta[63:2];
    trans_ack_64   = tr_64;
    rd_tlp_h_valid = !rst && rd_q.size() > 0;
    if (rd_q.size() > 0) begin
      rd_tlp_h_addr = rd_q[0].addr; rd_tlp_h_len = rd_q[0].len; rd_tlp_h_tag = rd_q[0].tag;
      rd_tlp_h_be_first = rd_q[0].bef; rd_tlp_h_be_last = rd_q[0].bel;
      rd_tlp_h_tc = rd_q[0].tc; rd_tlp_h_attr = rd_q[0].attr;
    end
    wr_tlp_h_valid = !rst && wr_q.size() > 0;
    if (wr_q.size() > 0) begin
      wr_tlp_h_addr = wr_q[0].addr; wr_tlp_h_len = wr_q[0].len;
      wr_tlp_h_be_first = wr_q[0].bef; wr_tlp_h_be_last = wr_q[0].bel;
      wr_tlp_h_tc = wr_q[0].tc; wr_tlp_h_attr = wr_q[0].attr;
    end
    wr_tlp_d_valid = !rst && pd_q.size() > 0 && (!d_stall || $urandom_range(0, 1) == 1);
    wr_tlp_d_data  = (pd_q.size() > 0) ? pd_q[0] : 32'd0;
    tlp_ready      = !bp || $urandom_range(0, 1) == 1;
    #1;
    cyc++;
    if (rd_tlp_h_valid && rd_tlp_h_ready) begin grants.push_back(0); rd_q.delete(0); end
    if (wr_tlp_h_valid && wr_tlp_h_ready) begin grants.push_back(1); wr_q.delete(0); end
    if (wr_tlp_d_valid && wr_tlp_d_ready) pd_q.delete(0);
    if (prev_stall) check("stall_hold", {tlp_valid, tlp_last, tlp_data}, prev_word);
    prev_stall = tlp_valid && !tlp_ready;
    prev_word  = {tlp_valid, tlp_last, tlp_data};
    if (tlp_valid && tlp_ready) begin
      obs.push_back({tlp_last, tlp_data});
      obs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got 0x%0h expected no word", {tlp_last, tlp_data});
      end else begin
        check("tlp_word", {tlp_last, tlp_data}, exp_q[0]);
        exp_q.delete(0);
      end
    end
  endtask

  task automatic drain(input string name, input int maxc);
    int n = 0;
    while ((exp_q.size() > 0 || rd_q.size() > 0 || wr_q.size() > 0 || pd_q.size() > 0) && n < maxc) begin
      tick(); n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s timeout: %0d words outstanding, required 0", name, exp_q.size());
    end
    repeat (4) tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1; prev_stall = 1'b0;
    rd_q.delete(); wr_q.delete(); pd_q.delete(); exp_q.delete();
    tick();
  endtask

  initial begin
    hdr_t h;
    hdr_t rdh[6];
    hdr_t wrh[3];
    int   exp_g[6];
    int   ord[$];
    int   last_t, run_t, ri, wi, pick, nl, n;

    bus_number = 8'h12; dev_number = 5'h03; func_number = 3'h4;
    id = {bus_number, dev_number, func_number};
    trans_ack = 0; trans_ack_addr = '0; trans_ack_64 = 0;
    rd_tlp_h_valid = 0; rd_tlp_h_addr = '0; rd_tlp_h_len = '0; rd_tlp_h_tag = '0;
    rd_tlp_h_be_first = '0; rd_tlp_h_be_last = '0; rd_tlp_h_tc = '0; rd_tlp_h_attr = '0;
    wr_tlp_h_valid = 0; wr_tlp_h_addr = '0; wr_tlp_h_len = '0;
    wr_tlp_h_be_first = '0; wr_tlp_h_be_last = '0; wr_tlp_h_tc = '0; wr_tlp_h_attr = '0;
    wr_tlp_d_valid = 0; wr_tlp_d_data = '0; tlp_ready = 1;

    // reset state
    repeat (3) tick();
    check("rst_tlp_valid", tlp_valid, 0);
    check("rst_tlp_last", tlp_last, 0);
    check("rst_tlp_data", tlp_data, 0);
    check("rst_trans_req", trans_req, 0);
    check("rst_readies", {rd_tlp_h_ready, wr_tlp_h_ready, wr_tlp_d_ready}, 0);
    rst = 1'b0;
    tick();

    // 3DW read, 64-bit translation demoted, latency and back-to-back words
    tr_hi = 32'h0; tr_or = 32'h8000_0000; tr_64 = 1'b1;
    obs.delete(); obs_cyc.delete(); grants.delete();
    h = '{1'b0, 30'(32'h1000 >> 2), 10'd4, 5'd3, 4'hF, 4'hF, 3'd0, 2'd0, 8'h00};
    rd_q.push_back(h); model_tlp(h);
    tick();
    check("rd_accept", grants.size(), 1);
    tick();
    check("trans_req_lat", trans_req, 1);
    tick();
    check("rd_h0_lat", {tlp_valid, tlp_last, tlp_data}, {2'b10, 32'h0000_0004});
    tick();
    check("rd_h1", {tlp_valid, tlp_last, tlp_data}, {2'b10, 32'h121C_03FF});
    tick();
    check("rd_h2", {tlp_valid, tlp_last, tlp_data}, {2'b11, 32'h8000_1000});
    drain("rd3dw", 50);
    check("rd3dw_words", obs.size(), 3);

    // 4DW write with len 0 (1024 DW)
    tr_hi = 32'h1; tr_or = 32'h0; tr_64 = 1'b1;
    obs.delete(); obs_cyc.delete();
    h = '{1'b1, 30'(32'h2000 >> 2), 10'd0, 5'd0, 4'hF, 4'hF, 3'd5, 2'b10, 8'h11};
    wr_q.push_back(h); model_tlp(h);
    drain("wr4dw_len0", 1300);
    check("wr_h0", obs_at(0), {1'b0, 32'h6050_2000});
    check("wr_h2", obs_at(2), {1'b0, 32'h0000_0001});
    check("wr_h3", obs_at(3), {1'b0, 32'h0000_2000});
    check("wr_words", obs.size(), 4 + 1024);
    nl = 0;
    foreach (obs[k]) if (obs[k][32]) nl++;
    check("wr_last_count", nl, 1);
    check("wr_last_pos", obs_at(1027), {1'b1, pword(8'h11, 1023)});

    // WRR with both sources valid, from reset state
    pulse_reset();
    rst = 1'b0;
    tick();
    tr_hi = 32'h0; tr_or = 32'h0; tr_64 = 1'b0;
    obs.delete(); obs_cyc.delete(); grants.delete();
    for (int k = 0; k < 6; k++) begin
      rdh[k] = '{1'b0, 30'(k * 16), 10'(k + 1), 5'(k + 8), 4'hF, 4'(k + 1), 3'(k), 2'(k), 8'h00};
      rd_q.push_back(rdh[k]);
    end
    for (int k = 0; k < 3; k++) begin
      wrh[k] = '{1'b1, 30'(32'h400 + k * 4), 10'd2, 5'd0, 4'hF, 4'hF, 3'(7 - k), 2'(k), 8'(8'h20 + k)};
      wr_q.push_back(wrh[k]);
    end
    last_t = 0; run_t = 0; ri = 0; wi = 0;
    while (ri < 6 || wi < 3) begin
      if (ri < 6 && wi < 3)
        pick = (run_t >= ((last_t == 0) ? RD_WEIGHT : WR_WEIGHT)) ? 1 - last_t : last_t;
      else
        pick = (ri < 6) ? 0 : 1;
      if (pick == last_t) run_t++;
      else begin last_t = pick; run_t = 1; end
      ord.push_back(pick);
      if (pick == 0) begin model_tlp(rdh[ri]); ri++; end
      else begin model_tlp(wrh[wi]); wi++; end
    end
    drain("wrr", 300);
    exp_g = '{0, 0, 1, 0, 0, 1};
    for (int k = 0; k < 6; k++)
      check("wrr_grant_literal", (k < grants.size()) ? grants[k] : -1, exp_g[k]);
    for (int k = 0; k < ord.size(); k++)
      check("wrr_grant_model", (k < grants.size()) ? grants[k] : -1, ord[k]);
    check("rd3dw_consecutive", cyc_at(2) - cyc_at(0), 2);
    check("header_gap", cyc_at(3) - cyc_at(2), 2);

    // Backpressure and payload stalls on a 4DW len-8 write, then a 4DW read
    tr_hi = 32'h3; tr_or = 32'h0; tr_64 = 1'b1;
    bp = 1'b1; d_stall = 1'b1;
    obs.delete(); obs_cyc.delete();
    h = '{1'b1, 30'(32'h3000 >> 2), 10'd8, 5'd0, 4'h3, 4'hC, 3'd2, 2'b01, 8'h40};
    wr_q.push_back(h); model_tlp(h);
    drain("bp_write", 400);
    check("bp_write_words", obs.size(), 4 + 8);
    obs.delete();
    h = '{1'b0, 30'(32'h3100 >> 2), 10'd1, 5'd7, 4'h1, 4'h0, 3'd1, 2'b11, 8'h00};
    rd_q.push_back(h); model_tlp(h);
    drain("bp_read", 200);
    check("bp_read_words", obs.size(), 4);
    bp = 1'b0; d_stall = 1'b0;

    // Reset during payload word 3 of 6, then a normal 3DW read
    tr_hi = 32'h0; tr_or = 32'h0; tr_64 = 1'b0;
    h = '{1'b1, 30'(32'h5000 >> 2), 10'd6, 5'd0, 4'hF, 4'hF, 3'd0, 2'd0, 8'h50};
    wr_q.push_back(h); model_tlp(h);
    n = 0;
    while (pd_q.size() > 3 && n < 100) begin tick(); n++; end
    check("reach_word3", pd_q.size(), 3);
    pulse_reset();
    check("rst_mid_valid", tlp_valid, 0);
    check("rst_mid_trans_req", trans_req, 0);
    rst = 1'b0;
    tick();
    obs.delete(); obs_cyc.delete();
    h = '{1'b0, 30'(32'h6000 >> 2), 10'd16, 5'd9, 4'hF, 4'h7, 3'd3, 2'd0, 8'h00};
    rd_q.push_back(h); model_tlp(h);
    drain("post_rst_read", 50);
    check("post_rst_words", obs.size(), 3);
    check("post_rst_h0", obs_at(0), {1'b0, 32'h0030_0010});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dlsc_pcie_s6_outbound_tlp_wrr.md
# dlsc_pcie_s6_outbound_tlp_wrr

Outbound TLP generator for the Spartan-6 PCIe endpoint. It is the next generation of the single-priority outbound formatter. It takes read and write request headers plus write payload and emits 32-bit memory-request TLPs to the core's transmit path. New in this generation:
- weighted round-robin read/write arbitration
- traffic-class and attribute fields
- automatic 3DW demotion when the translated upper address is zero
- correct 1024-DW handling for length 0
- a fixed-latency registered output stage

## Interface
Parameters:
- ADDR, 32, width of untranslated byte address; bits [ADDR-1:2] carried.
- TAG, 5, read tag width (1..8).
- RD_WEIGHT, 2, maximum consecutive read grants while a write is pending (1..15).
- WR_WEIGHT, 2, maximum consecutive write grants while a read is pending (1..15).

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- trans_req  out  1  header held, awaiting translation
- trans_req_addr  out  ADDR-2  held header address [ADDR-1:2]
- trans_ack  in  1  translation valid; held until the header retires
- trans_ack_addr  in  62  translated address [63:2]
- trans_ack_64  in  1  translator requests 64-bit addressing
- rd_tlp_h_ready  out  1  read header accept
- rd_tlp_h_valid  in  1  read header valid
- rd_tlp_h_addr  in  ADDR-2  read address
- rd_tlp_h_len  in  10  length in DW; 0 = 1024
- rd_tlp_h_tag  in  TAG  read tag
- rd_tlp_h_be_first / rd_tlp_h_be_last  in  4 each  byte enables
- rd_tlp_h_tc  in  3  traffic class
- rd_tlp_h_attr  in  2  {relaxed ordering, no snoop}
- wr_tlp_h_ready  out  1  write header accept
- wr_tlp_h_valid  in  1  write header valid
- wr_tlp_h_addr, wr_tlp_h_len, wr_tlp_h_be_first, wr_tlp_h_be_last, wr_tlp_h_tc, wr_tlp_h_attr  in  same widths as the read header fields
- wr_tlp_d_ready  out  1  payload accept
- wr_tlp_d_valid  in  1  payload valid
- wr_tlp_d_data  in  32  payload DW
- tlp_ready  in  1  downstream ready
- tlp_valid  out  1  TLP word valid
- tlp_data  out  32  TLP word
- tlp_last  out  1  final word of TLP
- bus_number / dev_number / func_number  in  8/5/3  requester ID

## Operation
- **Header slot.** A single header register (h_valid) is loaded only when empty.
  - rd_tlp_h_ready = !h_valid && rd_tlp_h_valid && grant_rd.
  - wr_tlp_h_ready is the same with grant_wr.
  - At most one is asserted per cycle.
- **Arbitration.** If only one source is valid, it is granted. If both are valid, the source favoured by the WRR state is granted. The WRR state is:
  - last-granted type plus a 4-bit run counter;
  - the counter increments on a same-type grant and resets to 1 on a type switch;
  - when both sources are valid and the run count reaches the weight of the last-granted type, the other type is granted;
  - after reset, reads are favoured.
- **Write tag.** Write tag is forced to 0.
- **Address width.** A 4DW header is used iff trans_ack_64 && trans_ack_addr[63:32] != 0. Otherwise a 3DW header is used with addr[31:2].
- **TLP layout.**
  - H0: [30] = write, [29] = 4DW, [28:24] = 0, [22:20] = tc, [13:12] = attr, [9:0] = len.
  - H1: [31:16] = {bus, dev, func}, [8+:TAG] = tag, [7:4] = be_last, [3:0] = be_first.
  - H2: upper address (4DW) or {addr[31:2], 2'b00} (3DW).
  - H3 (4DW only): {addr[31:2], 2'b00}.
  - DATA: write payload, len words (1024 when len = 0).
- **FSM states.** H0, H1, H2, H3, DATA. The FSM advances only on an internal word handshake.
  - H0 waits for h_valid && trans_ack.
  - H2 goes to H3 if 4DW. Otherwise it goes to DATA for a write, or H0 for a read.
  - H3 goes to DATA for a write, or H0 for a read.
  - DATA goes to H0 after the last payload word.
- **Header retire.** The header slot clears on the handshake of the final header word. trans_req drops the following cycle.
- **Payload counter.** 11 bits, loaded with (len == 0 ? 1024 : len) outside DATA. It decrements per payload handshake, and last is asserted when count == 1. Excess payload words are not consumed.
- **Reset.** Clears h_valid, the FSM (to H0), the WRR state and the output stage. Reset mid-TLP abandons the TLP; upstream sources must also be reset.
- **Reset values.** All outputs are 0 after reset: tlp_valid, tlp_last, tlp_data, trans_req, and all readies.

## Timing
- **Output stage.** Internal words enter a 2-entry skid register, so tlp_valid lags the internal handshake by exactly 1 cycle. The internal ready is the skid not-full flag, which is fully registered, so there is no combinational path from tlp_ready.
- **Header accept.** A header accepted in cycle N gives trans_req = 1 in cycle N+1.
- **First word.** With trans_ack already high, H0 appears on tlp_valid in cycle N+2.
- **Sustained throughput.** With tlp_ready held high, one word per cycle. A 3DW read occupies 3 consecutive cycles.
- **Header gap.** The next header can be accepted in the cycle after H2/H3 retires, so there is a 1-cycle header gap between back-to-back TLPs.
- **Data stalls.** Payload stalls (wr_tlp_d_valid low) insert bubbles with no word loss.
- **Downstream stalls.** tlp_ready low holds tlp_data and tlp_last stable.

## Test plan
- **3DW read.** Read with addr 0x1000, len 4, tag 3, be 0xF/0xF, tc 0, attr 0; translator returns 0x0000_0000_8000_1000 with trans_ack_64 = 1. Expect 3 words: 0x0000_0004, {ID, 0x03, 0xFF}, 0x8000_1000 with last. This demotes a 64-bit translation to 3DW.
- **4DW write, len 0.** Write with len 0 to translated address 0x1_0000_2000, tc 5, attr 2'b10. Expect:
  - H0 = 0x6050_2000;
  - H2 = 0x0000_0001, H3 = 0x0000_2000;
  - 1024 payload words, last only on the 1024th.
- **WRR, RD_WEIGHT = 2, WR_WEIGHT = 1.** Both sources continuously valid. Expect grant sequence R, R, W, R, R, W.
- **Backpressure.** Toggle tlp_ready randomly at 50% during a len-8 write. Expect the output stream to match the reference order exactly with no duplicated or lost words.
- **Reset mid-payload.** Assert rst during DATA word 3 of 6. Expect:
  - next cycle: tlp_valid = 0, trans_req = 0;
  - a subsequent 3DW read completes normally.
